// File: rtl/gpio_hex_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_hex_display_if
//  Description : Bundles the GPIO word/radix inputs and the eight
//                seven-segment digit outputs plus status of the hex display.
//                master : drives value_in/hex_mode, observes the display.
//                slave  : the display converter itself.
//  Ports       : value_in[31:0], hex_mode  (master -> slave)
//                hex0..hex7[6:0] active-low segments, busy, overflow
//                                          (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface gpio_hex_display_if;
  logic [31:0] value_in;
  logic        hex_mode;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic [6:0]  hex4;
  logic [6:0]  hex5;
  logic [6:0]  hex6;
  logic [6:0]  hex7;
  logic        busy;
  logic        overflow;

  modport master (
    output value_in, hex_mode,
    input  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, busy, overflow
  );

  modport slave (
    input  value_in, hex_mode,
    output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, busy, overflow
  );
endinterface
`default_nettype wire

// File: rtl/gpio_hex_display.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_hex_display
//  Description : Shows a 32-bit GPIO word on eight active-low seven-segment
//                digits, either as hexadecimal or as decimal (serial
//                double-dabble, 32 cycles). Decimal values above 99_999_999
//                show dashes and raise overflow. Optional leading-zero
//                blanking.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - slave modport: value_in, hex_mode in;
//                       hex0..hex7, busy, overflow out
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_hex_display #(
  parameter int unsigned BLANK_LZ = 1
) (
  input  wire                 clk,
  input  wire                 rst,
  gpio_hex_display_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    LOAD_OUT = 2'd2
  } state_t;

  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;
  localparam logic [31:0] DEC_MAX   = 32'd99_999_999;

  state_t          state_q, state_d;
  logic            cap_valid_q, cap_valid_d;
  logic [31:0]     cap_val_q, cap_val_d;
  logic            cap_hex_q, cap_hex_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     bcd_q, bcd_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [7:0][6:0] hex_q, hex_d;
  logic            ovf_q, ovf_d;

  logic [31:0]     bcd_adj;
  logic [7:0][3:0] nib;
  logic [7:0]      lit;
  logic            dec_ovf;
  logic [7:0][6:0] seg_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Double-dabble correction: each BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int k = 0; k < 8; k++) begin
      bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                     : bcd_q[4*k +: 4];
    end
  end

  // Digit source for the display load: raw nibbles in hex mode, BCD otherwise.
  // A digit is lit once any digit at or above it is nonzero; hex0 always lit.
  always_comb begin
    logic lead;
    lead = 1'b0;
    lit  = '0;
    for (int k = 7; k >= 0; k--) begin
      nib[k] = cap_hex_q ? cap_val_q[4*k +: 4] : bcd_q[4*k +: 4];
    end
    for (int k = 7; k >= 1; k--) begin
      lead   = lead | (nib[k] != 4'd0);
      lit[k] = lead | (BLANK_LZ == 0);
    end
    lit[0]  = 1'b1;
    dec_ovf = !cap_hex_q && (cap_val_q > DEC_MAX);
  end

  for (genvar g = 0; g < 8; g++) begin : g_digit
    // Dash display overrides blanking.
    assign seg_next[g] = dec_ovf ? SEG_DASH : (lit[g] ? seg7(nib[g]) : SEG_BLANK);
  end

  always_comb begin
    state_d     = state_q;
    cap_valid_d = cap_valid_q;
    cap_val_d   = cap_val_q;
    cap_hex_d   = cap_hex_q;
    src_d       = src_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    hex_d       = hex_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (!cap_valid_q || ({bus.hex_mode, bus.value_in} != {cap_hex_q, cap_val_q})) begin
          cap_valid_d = 1'b1;
          cap_val_d   = bus.value_in;
          cap_hex_d   = bus.hex_mode;
          src_d       = bus.value_in;
          bcd_d       = '0;
          cnt_d       = '0;
          state_d     = bus.hex_mode ? LOAD_OUT : SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[30:0], src_q[31]};
        src_d = {src_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = LOAD_OUT;
        end
      end
      LOAD_OUT: begin
        hex_d   = seg_next;
        ovf_d   = dec_ovf;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cap_valid_q <= 1'b0;
      cap_val_q   <= '0;
      cap_hex_q   <= 1'b0;
      src_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      hex_q       <= {8{SEG_BLANK}};
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_valid_q <= cap_valid_d;
      cap_val_q   <= cap_val_d;
      cap_hex_q   <= cap_hex_d;
      src_q       <= src_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      hex_q       <= hex_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.hex0     = hex_q[0];
  assign bus.hex1     = hex_q[1];
  assign bus.hex2     = hex_q[2];
  assign bus.hex3     = hex_q[3];
  assign bus.hex4     = hex_q[4];
  assign bus.hex5     = hex_q[5];
  assign bus.hex6     = hex_q[6];
  assign bus.hex7     = hex_q[7];
  assign bus.busy     = (state_q != IDLE);
  assign bus.overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_hex_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_hex_display
//  Description : Scoreboard bench for gpio_hex_display. Stimulus pushes the
//                hand-computed display word, overflow flag and busy length;
//                monitors pop on each completed conversion (busy falling
//                without reset). dut0 blanks leading zeros, dut1 does not
//                and always sees decimal 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_hex_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011,
                         SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110,
                         BL = 7'b1111111, DS = 7'b0111111;

  typedef struct {
    logic [55:0] seg;   // {hex7 .. hex0}
    logic        ovf;
    int          len;   // cycles busy was high
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_hex_display_if bus0();
  gpio_hex_display_if bus1();

  gpio_hex_display #(.BLANK_LZ(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gpio_hex_display #(.BLANK_LZ(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  logic rst_e  = 1'b1;

  always @(posedge clk) rst_e = rst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push0(input logic [55:0] seg, input logic ovf, input int len);
    exp_t e;
    e.seg = seg; e.ovf = ovf; e.len = len;
    q0.push_back(e);
  endtask

  task automatic push1();
    exp_t e;
    e.seg = {8{S0}}; e.ovf = 1'b0; e.len = 33;
    q1.push_back(e);
  endtask

  function automatic logic [55:0] disp0();
    return {bus0.hex7, bus0.hex6, bus0.hex5, bus0.hex4,
            bus0.hex3, bus0.hex2, bus0.hex1, bus0.hex0};
  endfunction

  function automatic logic [55:0] disp1();
    return {bus1.hex7, bus1.hex6, bus1.hex5, bus1.hex4,
            bus1.hex3, bus1.hex2, bus1.hex1, bus1.hex0};
  endfunction

  // Monitor for dut0: pops on conversion completion, also checks that the
  // display never moves except at a load or a reset.
  int          bcnt0 = 0;
  logic        pbusy0 = 1'b0;
  logic [55:0] prev0 = '0;
  always @(negedge clk) begin
    logic [55:0] act;
    exp_t e;
    act = disp0();
    if (rst_e) begin
      bcnt0 = 0;
    end else if (bus0.busy) begin
      bcnt0++;
      check("dut0 hold while busy", {8'd0, act}, {8'd0, prev0});
    end else if (pbusy0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected output: got %h required none", act);
      end else begin
        e = q0.pop_front();
        check("dut0 digits", {8'd0, act}, {8'd0, e.seg});
        check("dut0 overflow", {63'd0, bus0.overflow}, {63'd0, e.ovf});
        check("dut0 busy length", 64'(bcnt0), 64'(e.len));
      end
      bcnt0 = 0;
    end else begin
      check("dut0 hold while idle", {8'd0, act}, {8'd0, prev0});
    end
    prev0  = act;
    pbusy0 = bus0.busy;
  end

  int   bcnt1 = 0;
  logic pbusy1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_e) begin
      bcnt1 = 0;
    end else if (bus1.busy) begin
      bcnt1++;
    end else if (pbusy1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected output: got %h required none", disp1());
      end else begin
        e = q1.pop_front();
        check("dut1 digits", {8'd0, disp1()}, {8'd0, e.seg});
        check("dut1 overflow", {63'd0, bus1.overflow}, {63'd0, e.ovf});
        check("dut1 busy length", 64'(bcnt1), 64'(e.len));
      end
      bcnt1 = 0;
    end
    pbusy1 = bus1.busy;
  end

  task automatic set_in(input logic [31:0] v, input logic h);
    @(posedge clk);
    #1;
    bus0.value_in = v;
    bus0.hex_mode = h;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(posedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !bus0.busy && !bus1.busy) break;
    end
    @(negedge clk);
    if (i >= maxc) begin
      checks++; errors++;
      $display("FAIL timeout %s: got %0d pending required 0", name, q0.size() + q1.size());
    end
  endtask

  initial begin
    bus0.value_in = 32'h11;
    bus0.hex_mode = 1'b0;
    bus1.value_in = 32'd0;
    bus1.hex_mode = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset dut0 digits", {8'd0, disp0()}, {8'd0, {8{BL}}});
    check("reset dut0 busy", {63'd0, bus0.busy}, 64'd0);
    check("reset dut0 overflow", {63'd0, bus0.overflow}, 64'd0);
    check("reset dut1 digits", {8'd0, disp1()}, {8'd0, {8{BL}}});
    rst = 1'b0;
    // 17 decimal, and dut1 shows 00000000.
    push0({BL, BL, BL, BL, BL, BL, S1, S7}, 1'b0, 33);
    push1();
    wait_idle("dec 17", 100);

    set_in(32'hDEADBEEF, 1'b1);
    push0({SD, SE, SA, SD, SB, SE, SE, SF}, 1'b0, 1);
    wait_idle("hex DEADBEEF", 20);

    set_in(32'd99_999_999, 1'b0);
    push0({8{S9}}, 1'b0, 33);
    wait_idle("dec max", 100);

    set_in(32'd100_000_000, 1'b0);
    push0({8{DS}}, 1'b1, 33);
    wait_idle("dec overflow", 100);

    set_in(32'd0, 1'b0);
    push0({BL, BL, BL, BL, BL, BL, BL, S0}, 1'b0, 33);
    wait_idle("dec zero", 100);

    set_in(32'h0000_0A05, 1'b1);
    push0({BL, BL, BL, BL, BL, SA, S0, S5}, 1'b0, 1);
    wait_idle("hex A05", 20);

    // Change mid-conversion: 12345 completes first, then 678.
    set_in(32'd12345, 1'b0);
    push0({BL, BL, BL, S1, S2, S3, S4, S5}, 1'b0, 33);
    push0({BL, BL, BL, BL, BL, S6, S7, S8}, 1'b0, 33);
    repeat (11) @(posedge clk);
    #1;
    bus0.value_in = 32'd678;
    wait_idle("dec 12345 then 678", 200);

    // Reset in the middle of SHIFT aborts; the same value converts again.
    set_in(32'd4096, 1'b0);
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort dut0 digits", {8'd0, disp0()}, {8'd0, {8{BL}}});
    check("abort dut0 busy", {63'd0, bus0.busy}, 64'd0);
    check("abort dut0 overflow", {63'd0, bus0.overflow}, 64'd0);
    rst = 1'b0;
    push0({BL, BL, BL, BL, S4, S0, S9, S6}, 1'b0, 33);
    push1();
    wait_idle("dec 4096 after reset", 100);

    check("dut0 queue drained", 64'(q0.size()), 64'd0);
    check("dut1 queue drained", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_hex_display.md
GPIO_HEX_DISPLAY -- requirements
Module: gpio_hex_display

Interface
REQ-001 SHALL provide parameter BLANK_LZ, default 1, where 1 enables leading-zero blanking.
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port value_in  input  32  word to display (driven by the CPU GPIO_out).
REQ-005 SHALL provide port hex_mode  input  1  display radix: 1 = hexadecimal, 0 = decimal.
REQ-006 SHALL provide ports hex0..hex7  output  7 each  seven-segment digits, active-low; bit0=a ... bit6=g; hex0 is least significant.
REQ-007 SHALL provide port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL provide port overflow  output  1  high while the displayed decimal value is out of range.

Function
REQ-009 SHALL implement FSM states IDLE, SHIFT, LOAD_OUT; busy = 1 in SHIFT and LOAD_OUT, 0 in IDLE.
REQ-010 In IDLE, SHALL compare {hex_mode, value_in} with the last captured pair; on mismatch or invalid pair, capture both; go to SHIFT if hex_mode=0, else to LOAD_OUT.
REQ-011 SHIFT SHALL run exactly 32 cycles of double-dabble on a 32-bit source and 8-digit BCD register: add 3 to each digit >= 5, then shift left, inserting source MSB; 5-bit counter; after 32nd cycle go to LOAD_OUT.
REQ-012 LOAD_OUT SHALL update hex0..hex7 and overflow in one cycle, then return to IDLE.
REQ-013 Latency: capture at edge N; outputs valid after edge N+33 (decimal) or N+1 (hex); the first comparison occurs on the following IDLE cycle.
REQ-014 Changes on value_in/hex_mode while busy=1 SHALL be ignored; conversion completes on the captured value; the new value is detected in the next IDLE cycle.
REQ-015 Hex mode: digit k SHALL show captured nibble [4k+3:4k]; overflow = 0.
REQ-016 Decimal mode: if captured value > 99_999_999, all digits SHALL be dash (7'b0111111) and overflow = 1; else the 8 BCD digits are shown and overflow = 0.
REQ-017 Segment codes SHALL be: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110; blank=1111111.
REQ-018 With BLANK_LZ=1, every digit above the most significant nonzero digit SHALL be blank; hex0 is never blanked (value 0 shows "0"); dash display is never blanked.
REQ-019 With BLANK_LZ=0, all eight digits SHALL always be shown.
REQ-020 Outputs SHALL hold their values between LOAD_OUT cycles.

Reset
REQ-021 While rst=1 at a rising edge: state IDLE, hex0..hex7 = 7'b1111111, busy = 0, overflow = 0, counter = 0, BCD register = 0, captured pair invalid.
REQ-022 Reset asserted during SHIFT or LOAD_OUT SHALL abort the conversion with no partial output update.
REQ-023 The first IDLE cycle after reset release SHALL always start a conversion (captured pair invalid).

Verification
REQ-024 Reset, then value_in=32'h11, hex_mode=0 -> busy high 33 cycles; then hex0=1111000 (7), hex1=1111001 (1), hex2..hex7=1111111, overflow=0.
REQ-025 hex_mode=1, value_in=32'hDEADBEEF -> after 2 edges hex7..hex0 = d,E,A,d,b,E,E,F codes; no blanking; overflow=0.
REQ-026 Decimal 99_999_999 -> all digits 0010000, overflow=0; then 100_000_000 -> all digits 0111111, overflow=1.
REQ-027 Decimal value_in=0 with BLANK_LZ=1 -> hex0=1000000, hex1..hex7 blank; with BLANK_LZ=0 all eight digits 1000000.
REQ-028 value_in 12345 -> 678 at SHIFT cycle 10 -> display first shows 12345, then after a second 34-cycle conversion shows 678; no intermediate garbage.
REQ-029 rst pulsed at SHIFT cycle 20 -> next edge all digits blank, busy=0; after release a new conversion of current value_in starts.
